// File: rtl/rvfpm_result_buffer_pkg.sv
// Shared types for the rvfpm result side: buffered result entries and
// the per-ID commit state.
package pa_rvfpm;

    localparam int X_ID_WIDTH_C = 4;
    localparam int XLEN_C       = 32;
    localparam int FFLAGS_W     = 5;

    typedef enum logic [1:0] {
        CS_NONE   = 2'd0,
        CS_COMMIT = 2'd1,
        CS_KILL   = 2'd2
    } commit_state_e;

    typedef struct packed {
        logic [X_ID_WIDTH_C-1:0] id;
        logic [XLEN_C-1:0]       data;
        logic [4:0]              rd;
        logic                    we;
        logic [FFLAGS_W-1:0]     fflags;
    } result_entry_t;

endpackage

// File: rtl/rvfpm_commit_table.sv
// Per-ID commit/kill state, written by the XIF commit interface and
// cleared when the matching result leaves the buffer.
module rvfpm_commit_table
    import pa_rvfpm::*;
#(
    parameter int X_ID_WIDTH = X_ID_WIDTH_C
) (
    input  logic                  ck,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [X_ID_WIDTH-1:0] wr_id,
    input  logic                  wr_kill,
    input  logic                  clr_en,
    input  logic [X_ID_WIDTH-1:0] clr_id,
    input  logic [X_ID_WIDTH-1:0] rd_id,
    output logic [1:0]            rd_state
);

    localparam int N = 2 ** X_ID_WIDTH;

    commit_state_e tbl [N];

    // Write follows clear so a commit for a reused ID survives the pop.
    always_ff @(posedge ck) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                tbl[i] <= CS_NONE;
            end
        end else begin
            if (clr_en) begin
                tbl[clr_id] <= CS_NONE;
            end
            if (wr_en) begin
                tbl[wr_id] <= wr_kill ? CS_KILL : CS_COMMIT;
            end
        end
    end

    assign rd_state = tbl[rd_id];

endmodule

// File: rtl/rvfpm_result_buffer.sv
// In-order FPU result FIFO that holds each result until its ID is
// committed (delivered on the XIF result port) or killed (dropped).
module rvfpm_result_buffer
    import pa_rvfpm::*;
#(
    parameter int X_ID_WIDTH = X_ID_WIDTH_C,
    parameter int XLEN       = XLEN_C,
    parameter int DEPTH      = 4
) (
    input  logic                       ck,
    input  logic                       rst,
    input  logic                       res_in_valid,
    output logic                       res_in_ready,
    input  logic [X_ID_WIDTH-1:0]      res_in_id,
    input  logic [XLEN-1:0]            res_in_data,
    input  logic [4:0]                 res_in_rd,
    input  logic                       res_in_we,
    input  logic [4:0]                 res_in_fflags,
    input  logic                       commit_valid,
    input  logic [X_ID_WIDTH-1:0]      commit_id,
    input  logic                       commit_kill,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [X_ID_WIDTH-1:0]      result_id,
    output logic [XLEN-1:0]            result_data,
    output logic [4:0]                 result_rd,
    output logic                       result_we,
    output logic [4:0]                 result_fflags,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    result_entry_t mem [DEPTH];
    result_entry_t head;
    result_entry_t wdata;

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          push;
    logic          pop;
    logic          drop;
    logic          empty;
    logic [1:0]    hd_raw;
    commit_state_e hd_state;

    assign empty        = (cnt == '0);
    assign head         = mem[rptr];
    assign hd_state     = commit_state_e'(hd_raw);
    assign res_in_ready = !rst && (cnt < CW'(DEPTH));
    assign push         = res_in_valid && res_in_ready;

    always_comb begin
        result_valid = 1'b0;
        drop         = 1'b0;
        if (!empty) begin
            unique case (hd_state)
                CS_COMMIT: result_valid = 1'b1;
                CS_KILL:   drop         = 1'b1;
                default:   ;
            endcase
        end
    end

    assign pop = (result_valid && result_ready) || drop;

    assign wdata = '{
        id:     res_in_id,
        data:   res_in_data,
        rd:     res_in_rd,
        we:     res_in_we,
        fflags: res_in_fflags
    };

    always_ff @(posedge ck) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge ck) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push) wptr <= wptr + PW'(1);
            if (pop)  rptr <= rptr + PW'(1);
            unique case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    rvfpm_commit_table #(
        .X_ID_WIDTH(X_ID_WIDTH)
    ) u_table (
        .ck       (ck),
        .rst      (rst),
        .wr_en    (commit_valid),
        .wr_id    (commit_id),
        .wr_kill  (commit_kill),
        .clr_en   (pop),
        .clr_id   (head.id),
        .rd_id    (head.id),
        .rd_state (hd_raw)
    );

    assign result_id     = result_valid ? head.id     : '0;
    assign result_data   = result_valid ? head.data   : '0;
    assign result_rd     = result_valid ? head.rd     : '0;
    assign result_we     = result_valid ? head.we     : 1'b0;
    assign result_fflags = result_valid ? head.fflags : '0;
    assign count         = cnt;

endmodule
